// File: rtl/boot_ctrl.sv
// boot_ctrl: owns the core run/load life cycle (LOAD -> RUN -> HALTED), turns host write
//   commands into single-cycle imem/dmem write strobes and drives the core reset.
// Latency: command acceptance to strobe or core_rstn_o change is 1 cycle; exit event to
//   core_rstn_o falling is 1 cycle.
// Backpressure: host_ready_o drops in RUN for WR_INST/WR_DATA only; START/STOP are
//   always accepted.
//
// Ports:
//   clk_i, rstn_i                 clock, async active-low reset
//   host_valid_i/host_ready_o     command handshake; host_cmd_i/addr_i/data_i command payload
//   imem_we_o, dmem_we_o          one-cycle write strobes; mem_addr_o/mem_data_o registered payload
//   core_rstn_o, running_o        core reset (active-low) and RUN indication, both registered
//   rf_wr_en_i, rf_wr_addr_i      core register-file write observation (halt register detect)
//   wdt_limit_i                   watchdog limit, 0 disables
//   run_cycles_o, halt_cause_o    run-cycle counter and latched halt cause
//
// Optional feature: define BOOT_WATCHDOG_EN to build the watchdog compare (cause 11).
// Without it wdt_limit_i is ignored and runs end only on STOP or the halt register.

module boot_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int CNT_W    = 32,
  parameter int HALT_REG = 31
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              host_valid_i,
  output logic              host_ready_o,
  input  logic [1:0]        host_cmd_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [31:0]       host_data_i,
  output logic              imem_we_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              core_rstn_o,
  input  logic              rf_wr_en_i,
  input  logic [4:0]        rf_wr_addr_i,
  input  logic [CNT_W-1:0]  wdt_limit_i,
  output logic [CNT_W-1:0]  run_cycles_o,
  output logic              running_o,
  output logic [1:0]        halt_cause_o
);

  localparam logic [1:0] CMD_WR_INST = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_START   = 2'b10;
  localparam logic [1:0] CMD_STOP    = 2'b11;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_STOP = 2'b01;
  localparam logic [1:0] CAUSE_HALT = 2'b10;
  localparam logic [1:0] CAUSE_WDT  = 2'b11;

  localparam logic [4:0]       HALT_IDX = 5'(HALT_REG);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                imem_we_q, imem_we_d;
  logic                dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_data_q, mem_data_d;
  logic                core_rstn_q, core_rstn_d;
  logic                running_q, running_d;
  logic [CNT_W-1:0]    run_cycles_q, run_cycles_d;
  logic [1:0]          halt_cause_q, halt_cause_d;

  logic                accept;
  logic                halt_hit;
  logic                wdt_hit;

  // Writes are refused only while the core is running; START/STOP (cmd[1]=1) always pass.
  assign host_ready_o = (state_q != S_RUN) || host_cmd_i[1];
  assign accept       = host_valid_i && host_ready_o;
  assign halt_hit     = rf_wr_en_i && (rf_wr_addr_i == HALT_IDX);

`ifdef BOOT_WATCHDOG_EN
  // Compare against the registered count, so limit N gives N+1 cycles out of reset.
  assign wdt_hit = (wdt_limit_i != '0) && (run_cycles_q == wdt_limit_i);
`else
  assign wdt_hit = 1'b0;
  logic unused_wdt_limit;
  assign unused_wdt_limit = ^wdt_limit_i;
`endif

  always_comb begin
    state_d      = state_q;
    imem_we_d    = 1'b0;
    dmem_we_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    run_cycles_d = run_cycles_q;
    halt_cause_d = halt_cause_q;

    unique case (state_q)
      S_LOAD, S_HALTED: begin
        if (accept) begin
          unique case (host_cmd_i)
            CMD_WR_INST: begin
              imem_we_d  = 1'b1;
              mem_addr_d = host_addr_i;
              mem_data_d = host_data_i;
            end
            CMD_WR_DATA: begin
              dmem_we_d  = 1'b1;
              mem_addr_d = host_addr_i;
              mem_data_d = host_data_i;
            end
            CMD_START: begin
              state_d      = S_RUN;
              run_cycles_d = '0;
              halt_cause_d = CAUSE_NONE;
            end
            default: ; // STOP while not running has no effect
          endcase
        end
      end
      S_RUN: begin
        // Exit priority: host STOP, then halt register, then watchdog.
        // The counter does not advance on the exit cycle, so it freezes at the compared value.
        if (accept && (host_cmd_i == CMD_STOP)) begin
          state_d      = S_HALTED;
          halt_cause_d = CAUSE_STOP;
        end else if (halt_hit) begin
          state_d      = S_HALTED;
          halt_cause_d = CAUSE_HALT;
        end else if (wdt_hit) begin
          state_d      = S_HALTED;
          halt_cause_d = CAUSE_WDT;
        end else if (run_cycles_q != CNT_MAX) begin
          run_cycles_d = run_cycles_q + CNT_ONE;
        end
      end
      default: state_d = S_LOAD;
    endcase

    core_rstn_d = (state_d == S_RUN);
    running_d   = (state_d == S_RUN);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_LOAD;
      imem_we_q    <= 1'b0;
      dmem_we_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      core_rstn_q  <= 1'b0;
      running_q    <= 1'b0;
      run_cycles_q <= '0;
      halt_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      imem_we_q    <= imem_we_d;
      dmem_we_q    <= dmem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      core_rstn_q  <= core_rstn_d;
      running_q    <= running_d;
      run_cycles_q <= run_cycles_d;
      halt_cause_q <= halt_cause_d;
    end
  end

  assign imem_we_o    = imem_we_q;
  assign dmem_we_o    = dmem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign core_rstn_o  = core_rstn_q;
  assign running_o    = running_q;
  assign run_cycles_o = run_cycles_q;
  assign halt_cause_o = halt_cause_q;

endmodule

// File: tb/tb_boot_ctrl.sv
// tb_boot_ctrl: self-checking bench for boot_ctrl; cycle vectors from a table, expected
//   post-edge outputs queued on drive and popped after the clock edge.
// A narrow counter (CW bits) makes saturation reachable in a short run.

module tb_boot_ctrl;

  localparam int AW = 16;
  localparam int CW = 4;

  localparam logic [1:0] WR_INST = 2'b00;
  localparam logic [1:0] WR_DATA = 2'b01;
  localparam logic [1:0] START   = 2'b10;
  localparam logic [1:0] STOP    = 2'b11;

  logic          clk;
  logic          rst_n;
  logic          host_valid;
  logic          host_ready;
  logic [1:0]    host_cmd;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_data;
  logic          imem_we;
  logic          dmem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data;
  logic          core_rstn;
  logic          rf_wr_en;
  logic [4:0]    rf_wr_addr;
  logic [CW-1:0] wdt_limit;
  logic [CW-1:0] run_cycles;
  logic          running;
  logic [1:0]    halt_cause;

  boot_ctrl #(.ADDR_W(AW), .CNT_W(CW), .HALT_REG(31)) dut (
    .clk_i        (clk),
    .rstn_i       (rst_n),
    .host_valid_i (host_valid),
    .host_ready_o (host_ready),
    .host_cmd_i   (host_cmd),
    .host_addr_i  (host_addr),
    .host_data_i  (host_data),
    .imem_we_o    (imem_we),
    .dmem_we_o    (dmem_we),
    .mem_addr_o   (mem_addr),
    .mem_data_o   (mem_data),
    .core_rstn_o  (core_rstn),
    .rf_wr_en_i   (rf_wr_en),
    .rf_wr_addr_i (rf_wr_addr),
    .wdt_limit_i  (wdt_limit),
    .run_cycles_o (run_cycles),
    .running_o    (running),
    .halt_cause_o (halt_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          vld;
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic          rf_en;
    logic [4:0]    rf_addr;
    logic [CW-1:0] wdt;
    logic          exp_rdy;
    logic          exp_imem;
    logic          exp_dmem;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_data;
    logic          exp_rstn;
    logic [1:0]    exp_cause;
    logic [CW-1:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  logic [AW-1:0] x_a;
  logic [31:0]   x_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // rf < 0 means no register-file write this cycle.
  task automatic add(input logic vld, input logic [1:0] cmd, input logic [AW-1:0] addr,
                     input logic [31:0] data, input int rf, input logic [CW-1:0] wdt,
                     input logic rdy, input logic imem, input logic dmem,
                     input logic rstn, input logic [1:0] cause, input int cnt);
    vec_t v;
    logic [31:0] rfv;
    rfv         = rf;
    v.vld       = vld;
    v.cmd       = cmd;
    v.addr      = addr;
    v.data      = data;
    v.rf_en     = (rf >= 0);
    v.rf_addr   = rfv[4:0];
    v.wdt       = wdt;
    v.exp_rdy   = rdy;
    v.exp_imem  = imem;
    v.exp_dmem  = dmem;
    v.exp_addr  = x_a;
    v.exp_data  = x_d;
    v.exp_rstn  = rstn;
    v.exp_cause = cause;
    v.exp_cnt   = CW'(cnt);
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    host_valid = 1'b0;
    host_cmd   = WR_INST;
    host_addr  = '0;
    host_data  = '0;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_imem"},  imem_we,    0);
    chk({tag, "_dmem"},  dmem_we,    0);
    chk({tag, "_addr"},  mem_addr,   0);
    chk({tag, "_data"},  mem_data,   0);
    chk({tag, "_rstn"},  core_rstn,  0);
    chk({tag, "_run"},   running,    0);
    chk({tag, "_cnt"},   run_cycles, 0);
    chk({tag, "_cause"}, halt_cause, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    rst_n     = 1'b0;
    wdt_limit = '0;
    drive_idle();

    // ---------------- vector table ----------------
    x_a = '0; x_d = '0;
    x_a = 16'h0004; x_d = 32'h00500093;
    add(1, WR_INST, 16'h0004, 32'h00500093, -1, 0, 1, 1, 0, 0, 0, 0);
    add(0, WR_INST, 16'h0000, 32'h0,        -1, 0, 1, 0, 0, 0, 0, 0);
    x_a = 16'h0010; x_d = 32'hdeadbeef;
    add(1, WR_DATA, 16'h0010, 32'hdeadbeef, -1, 0, 1, 0, 1, 0, 0, 0);
    x_a = 16'h0011; x_d = 32'h12345678;
    add(1, WR_INST, 16'h0011, 32'h12345678, -1, 0, 1, 1, 0, 0, 0, 0);
    add(1, STOP,    16'hffff, 32'hffffffff, -1, 0, 1, 0, 0, 0, 0, 0);
    add(1, START,   16'h0,    32'h0,        -1, 0, 1, 0, 0, 1, 0, 0);
    add(1, WR_DATA, 16'h0abc, 32'h55555555, -1, 0, 0, 0, 0, 1, 0, 1);
    add(1, WR_DATA, 16'h0abc, 32'h55555555, -1, 0, 0, 0, 0, 1, 0, 2);
    add(1, START,   16'h0,    32'h0,        -1, 0, 1, 0, 0, 1, 0, 3);
    add(1, STOP,    16'h0,    32'h0,        -1, 0, 1, 0, 0, 0, 1, 3);
    x_a = 16'h0abc; x_d = 32'h55555555;
    add(1, WR_DATA, 16'h0abc, 32'h55555555, -1, 0, 1, 0, 1, 0, 1, 3);
    // halt register at run cycle 10; a write to x30 on the way must not halt
    add(1, START,   16'h0,    32'h0,        -1, 0, 1, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 10; k++)
      add(0, WR_INST, 16'h0, 32'h0, (k == 4) ? 30 : -1, 0, 0, 0, 0, 1, 0, k);
    add(0, WR_INST, 16'h0, 32'h0, 31, 0, 0, 0, 0, 0, 2, 10);
    add(0, WR_INST, 16'h0, 32'h0, -1, 0, 1, 0, 0, 0, 2, 10);
    // STOP + halt register (+ limit reached when the watchdog exists) -> STOP wins
    add(1, START, 16'h0, 32'h0, -1, 3, 1, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 3; k++)
      add(0, WR_INST, 16'h0, 32'h0, -1, 3, 0, 0, 0, 1, 0, k);
    add(1, STOP, 16'h0, 32'h0, 31, 3, 1, 0, 0, 0, 1, 3);
    // halt register + limit reached -> halt register wins
    add(1, START, 16'h0, 32'h0, -1, 2, 1, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 2; k++)
      add(0, WR_INST, 16'h0, 32'h0, -1, 2, 0, 0, 0, 1, 0, k);
    add(0, WR_INST, 16'h0, 32'h0, 31, 2, 0, 0, 0, 0, 2, 2);
    // watchdog limit 5: core out of reset for 6 cycles
    add(1, START, 16'h0, 32'h0, -1, 5, 1, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 5; k++)
      add(0, WR_INST, 16'h0, 32'h0, -1, 5, 0, 0, 0, 1, 0, k);
`ifdef BOOT_WATCHDOG_EN
    add(0, WR_INST, 16'h0, 32'h0, -1, 5, 0, 0, 0, 0, 3, 5);
    add(0, WR_INST, 16'h0, 32'h0, -1, 5, 1, 0, 0, 0, 3, 5);
    add(1, STOP,    16'h0, 32'h0, -1, 5, 1, 0, 0, 0, 3, 5);
`else
    add(0, WR_INST, 16'h0, 32'h0, -1, 5, 0, 0, 0, 1, 0, 6);
    add(0, WR_INST, 16'h0, 32'h0, -1, 5, 0, 0, 0, 1, 0, 7);
    add(1, STOP,    16'h0, 32'h0, -1, 5, 1, 0, 0, 0, 1, 7);
`endif
    // counter saturation, watchdog disabled by limit 0
    add(1, START, 16'h0, 32'h0, -1, 0, 1, 0, 0, 1, 0, 0);
    for (int k = 1; k <= 18; k++)
      add(0, WR_INST, 16'h0, 32'h0, -1, 0, 0, 0, 0, 1, 0, (k > 15) ? 15 : k);
    add(1, STOP, 16'h0, 32'h0, -1, 0, 1, 0, 0, 0, 1, 15);

    // ---------------- reset state ----------------
    #2;
    chk_all_zero("reset");
    chk("reset_ready", host_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- table run ----------------
    foreach (vecs[i]) begin
      @(negedge clk);
      host_valid = vecs[i].vld;
      host_cmd   = vecs[i].cmd;
      host_addr  = vecs[i].addr;
      host_data  = vecs[i].data;
      rf_wr_en   = vecs[i].rf_en;
      rf_wr_addr = vecs[i].rf_addr;
      wdt_limit  = vecs[i].wdt;
      #1;
      chk($sformatf("v%0d_ready", i), host_ready, vecs[i].exp_rdy);
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d_imem", i),  imem_we,    e.exp_imem);
      chk($sformatf("v%0d_dmem", i),  dmem_we,    e.exp_dmem);
      chk($sformatf("v%0d_addr", i),  mem_addr,   e.exp_addr);
      chk($sformatf("v%0d_data", i),  mem_data,   e.exp_data);
      chk($sformatf("v%0d_rstn", i),  core_rstn,  e.exp_rstn);
      chk($sformatf("v%0d_run", i),   running,    e.exp_rstn);
      chk($sformatf("v%0d_cause", i), halt_cause, e.exp_cause);
      chk($sformatf("v%0d_cnt", i),   run_cycles, e.exp_cnt);
    end

    // ---------------- async reset in the middle of a strobe ----------------
    @(negedge clk);
    wdt_limit  = '0;
    host_valid = 1'b1;
    host_cmd   = WR_INST;
    host_addr  = 16'h0040;
    host_data  = 32'h0a0a0a0a;
    @(posedge clk);
    #1;
    chk("strobe_pre_imem", imem_we, 1);
    chk("strobe_pre_addr", mem_addr, 16'h0040);
    rst_n = 1'b0;
    #1;
    chk_all_zero("strobe_rst");
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    #1;
    chk("strobe_rel_ready", host_ready, 1);

    // ---------------- async reset in the middle of a run ----------------
    @(negedge clk);
    host_valid = 1'b1;
    host_cmd   = START;
    @(negedge clk);
    drive_idle();
    repeat (3) @(negedge clk);
    chk("run_pre_rstn", core_rstn, 1);
    chk("run_pre_cnt", run_cycles, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("run_rst");
    @(negedge clk);
    rst_n = 1'b1;
    host_cmd = WR_DATA;
    #1;
    chk("run_rel_ready", host_ready, 1);
    host_valid = 1'b1;
    host_addr  = 16'h0077;
    host_data  = 32'h00c0ffee;
    @(posedge clk);
    #1;
    chk("run_rel_dmem", dmem_we, 1);
    chk("run_rel_addr", mem_addr, 16'h0077);
    chk("run_rel_data", mem_data, 32'h00c0ffee);
    @(negedge clk);
    drive_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/boot_ctrl.md
# boot_ctrl

Sequencer that owns the scalar core's run/load life cycle. It accepts host commands over a valid/ready port, turns write commands into single-cycle instruction- or data-memory write strobes, and holds the core in reset while loading. On command it releases the core and counts run cycles. It re-asserts core reset on a host stop, on a core write to a designated halt register, or on watchdog timeout. It sits between the host/debug loader and the core top: its strobes drive the imem/dmem debugger write ports, and its reset output drives the datapath `rstn_i`.

## Interface
- `ADDR_W`, 16, memory write address width
- `CNT_W`, 32, run-cycle counter and watchdog-limit width
- `HALT_REG`, 31, integer register index whose write ends a run
- `clk_i` in 1 — the single clock
- `rstn_i` in 1 — reset, asynchronous, active-low
- `host_valid_i` in 1 — command valid
- `host_ready_o` out 1 — command accepted when high with valid
- `host_cmd_i` in 2 — 00 WR_INST, 01 WR_DATA, 10 START, 11 STOP
- `host_addr_i` in ADDR_W — write address
- `host_data_i` in 32 — write data
- `imem_we_o` out 1 — instruction-memory write strobe
- `dmem_we_o` out 1 — data-memory write strobe
- `mem_addr_o` out ADDR_W — registered write address
- `mem_data_o` out 32 — registered write data
- `core_rstn_o` out 1 — core reset, active-low
- `rf_wr_en_i` in 1 — core register-file write event
- `rf_wr_addr_i` in 5 — register index of that write
- `wdt_limit_i` in CNT_W — watchdog limit; 0 disables the watchdog
- `run_cycles_o` out CNT_W — cycles spent in RUN
- `running_o` out 1 — state is RUN
- `halt_cause_o` out 2 — 00 none, 01 host stop, 10 halt register, 11 timeout

## Operation
- **States:** LOAD (the reset state), RUN, HALTED.
- **Reset values:** state LOAD; every registered output 0, including `core_rstn_o`, strobes, addr, data, counter and cause.
- **`host_ready_o` (combinational from state and cmd):**
  - 1 in LOAD and HALTED for every command.
  - 1 in RUN only for START and STOP.
  - 0 in RUN for WR_INST/WR_DATA; the host stalls.
- **Handshake:** a command is accepted on a cycle where `host_valid_i & host_ready_o`.
- **WR_INST / WR_DATA (LOAD or HALTED):**
  - Next cycle, `imem_we_o` or `dmem_we_o` is high for exactly one cycle.
  - `mem_addr_o`/`mem_data_o` carry the captured values and hold them until the next accepted write.
  - Back-to-back writes give one strobe per cycle. State does not change.
- **START (LOAD or HALTED):**
  - Next state RUN; `core_rstn_o`=1.
  - `run_cycles_o` cleared to 0; `halt_cause_o` cleared to 00.
- **START in RUN:** accepted, no effect.
- **RUN:** `run_cycles_o` increments by 1 each cycle and saturates at all-ones.
- **Exit from RUN to HALTED** (next cycle `core_rstn_o`=0; counter frozen; cause latched):
  - STOP accepted → cause 01.
  - `rf_wr_en_i` with `rf_wr_addr_i==HALT_REG` → cause 10.
  - Watchdog: `wdt_limit_i!=0` and `run_cycles_o==wdt_limit_i` → cause 11.
- **Priority on simultaneous exit events:** STOP > halt register > timeout.
- **STOP in LOAD or HALTED:** accepted, no effect.
- **Async reset mid-operation:** immediately forces LOAD with all outputs 0. Any in-flight strobe is dropped.

## Timing
- Command acceptance to strobe: 1 cycle.
- Command acceptance to `core_rstn_o` change: 1 cycle.
- Exit-event cycle to `core_rstn_o` falling: 1 cycle. The core sees at most one extra cycle out of reset after the event.
- `running_o` is registered and changes in the same cycle as `core_rstn_o`.
- The watchdog compare uses the registered counter value.
- Timeout after START, with limit N: `core_rstn_o` is high for N+1 cycles.

## Configuration
- `BOOT_WATCHDOG_EN` defined: watchdog compare and cause 11 are present.
- Not defined:
  - `wdt_limit_i` is ignored (left unconnected internally).
  - A run ends only by STOP or halt register.
  - Cause 11 is never produced.
  - The counter still runs and saturates.

## Test plan
- **Post-reset write:** release reset, WR_INST addr 0x0004 data 0x00500093 → one-cycle `imem_we_o`, `mem_addr_o`=0x0004, `mem_data_o`=0x00500093, `dmem_we_o`=0.
- **Write stall in RUN:** START, then WR_DATA held valid → `host_ready_o`=0 throughout RUN. STOP → HALTED, cause 01, pending WR_DATA accepted next cycle → `dmem_we_o` pulse.
- **Halt register:** START, drive `rf_wr_en_i`=1 with `rf_wr_addr_i`=31 at run cycle 10 → `core_rstn_o`=0 next cycle, cause 10, `run_cycles_o` frozen at 10 or 11 per the registered-counter rule.
- **Watchdog:** `wdt_limit_i`=5, START, no events → HALTED with cause 11, `run_cycles_o`=5, `core_rstn_o` high for 6 cycles. With `BOOT_WATCHDOG_EN` undefined → remains RUN.
- **Simultaneous exits:** STOP, halt-register write and limit reached in the same cycle → cause 01.
- **Reset mid-run:** assert `rstn_i` low asynchronously mid-RUN and mid-strobe → all outputs 0 immediately, state LOAD, `host_ready_o`=1 after release.
